// File: rtl/vdp_vram_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_read_responder
// Brief    : Arbitrates screen-mode and sprite VRAM reads onto one memory port
//            and routes in-order responses back. Optional macro
//            VDP_VRAM_SPRITE_RDATA8_EN enables the sprite byte-select output.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_read_responder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [16:0] screen_mode_vram_address,
    input  logic        screen_mode_vram_valid,
    output logic [31:0] screen_mode_vram_rdata,
    input  logic [16:0] sprite_vram_address,
    input  logic        sprite_vram_valid,
    output logic [31:0] sprite_vram_rdata,
    output logic [7:0]  sprite_vram_rdata8,
    output logic [16:0] vram_address,
    output logic        vram_valid,
    input  logic        vram_ready,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en
);

    localparam logic [1:0] c_MAX_OUTSTANDING = 2'd2;
    localparam logic       c_SRC_SCREEN      = 1'b0;
    localparam logic       c_SRC_SPRITE      = 1'b1;

    logic        r_scr_pend;
    logic [16:0] r_scr_addr;
    logic        r_spr_pend;
    logic [16:0] r_spr_addr;
    logic [1:0]  r_out_cnt;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic        r_tag_src [0:1];

    logic        w_issue;
    logic        w_issue_spr;
    logic        w_pop;
    logic [16:0] w_issue_addr;
    logic        w_pop_src;

    // Screen requests always win; the sprite slot is served only when screen is idle.
    assign w_issue      = vram_ready && (r_scr_pend || r_spr_pend)
                          && (r_out_cnt < c_MAX_OUTSTANDING);
    assign w_issue_spr  = !r_scr_pend;
    assign w_issue_addr = w_issue_spr ? r_spr_addr : r_scr_addr;
    assign w_pop        = vram_rdata_en && (r_out_cnt != 2'd0);
    assign w_pop_src    = r_tag_src[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scr_pend <= 1'b0;
            r_scr_addr <= 17'd0;
            r_spr_pend <= 1'b0;
            r_spr_addr <= 17'd0;
        end else begin
            // A fresh valid beats the clear from issuing: latest request wins.
            if (screen_mode_vram_valid) begin
                r_scr_pend <= 1'b1;
                r_scr_addr <= screen_mode_vram_address;
            end else if (w_issue && !w_issue_spr) begin
                r_scr_pend <= 1'b0;
            end
            if (sprite_vram_valid) begin
                r_spr_pend <= 1'b1;
                r_spr_addr <= sprite_vram_address;
            end else if (w_issue && w_issue_spr) begin
                r_spr_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_valid   <= 1'b0;
            vram_address <= 17'd0;
        end else begin
            vram_valid <= w_issue;
            if (w_issue) begin
                vram_address <= {w_issue_addr[16:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_cnt    <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_tag_src[0] <= c_SRC_SCREEN;
            r_tag_src[1] <= c_SRC_SCREEN;
        end else begin
            if (w_issue) begin
                r_tag_src[r_wr_ptr] <= w_issue_spr ? c_SRC_SPRITE : c_SRC_SCREEN;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_issue, w_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 2'd1;
                2'b01:   r_out_cnt <= r_out_cnt - 2'd1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            screen_mode_vram_rdata <= 32'd0;
            sprite_vram_rdata      <= 32'd0;
        end else if (w_pop) begin
            if (w_pop_src == c_SRC_SPRITE) begin
                sprite_vram_rdata <= vram_rdata;
            end else begin
                screen_mode_vram_rdata <= vram_rdata;
            end
        end
    end

`ifdef VDP_VRAM_SPRITE_RDATA8_EN
    logic [1:0] r_tag_a [0:1];
    logic [1:0] w_pop_a;

    assign w_pop_a = r_tag_a[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_a[0]         <= 2'd0;
            r_tag_a[1]         <= 2'd0;
            sprite_vram_rdata8 <= 8'd0;
        end else begin
            if (w_issue) begin
                r_tag_a[r_wr_ptr] <= w_issue_addr[1:0];
            end
            if (w_pop && (w_pop_src == c_SRC_SPRITE)) begin
                sprite_vram_rdata8 <= vram_rdata[{w_pop_a, 3'b000} +: 8];
            end
        end
    end
`else
    assign sprite_vram_rdata8 = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_vram_read_responder
// Brief    : Directed self-checking bench for vdp_vram_read_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_vram_read_responder;

    logic        clk;
    logic        reset_n;
    logic [16:0] screen_mode_vram_address;
    logic        screen_mode_vram_valid;
    logic [31:0] screen_mode_vram_rdata;
    logic [16:0] sprite_vram_address;
    logic        sprite_vram_valid;
    logic [31:0] sprite_vram_rdata;
    logic [7:0]  sprite_vram_rdata8;
    logic [16:0] vram_address;
    logic        vram_valid;
    logic        vram_ready;
    logic [31:0] vram_rdata;
    logic        vram_rdata_en;

    int n_cmp;
    int n_bad;

    vdp_vram_read_responder dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .screen_mode_vram_address (screen_mode_vram_address),
        .screen_mode_vram_valid   (screen_mode_vram_valid),
        .screen_mode_vram_rdata   (screen_mode_vram_rdata),
        .sprite_vram_address      (sprite_vram_address),
        .sprite_vram_valid        (sprite_vram_valid),
        .sprite_vram_rdata        (sprite_vram_rdata),
        .sprite_vram_rdata8       (sprite_vram_rdata8),
        .vram_address             (vram_address),
        .vram_valid               (vram_valid),
        .vram_ready               (vram_ready),
        .vram_rdata               (vram_rdata),
        .vram_rdata_en            (vram_rdata_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] data);
        vram_rdata    = data;
        vram_rdata_en = 1'b1;
        tick();
        vram_rdata_en = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (vram_valid !== 1'b0 || vram_address !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_cmd: got valid=%b addr=%h, want 0/0", vram_valid, vram_address);
        end
        n_cmp++;
        if (screen_mode_vram_rdata !== 32'd0 || sprite_vram_rdata !== 32'd0 || sprite_vram_rdata8 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_rdata: got scr=%h spr=%h spr8=%h, want 0", screen_mode_vram_rdata, sprite_vram_rdata, sprite_vram_rdata8);
        end
    endtask

    task automatic test_screen_read();
        vram_ready = 1'b1;
        screen_mode_vram_address = 17'h01235;
        screen_mode_vram_valid   = 1'b1;
        tick();
        screen_mode_vram_valid   = 1'b0;
        n_cmp++;
        if (vram_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL scr_no_early_issue: got valid=%b, want 0", vram_valid);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h01234) begin
            n_bad++;
            $display("FAIL scr_issue: got valid=%b addr=%h, want 1/01234", vram_valid, vram_address);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL scr_one_cycle: got valid=%b, want 0", vram_valid);
        end
        respond(32'h56781234);
        n_cmp++;
        if (screen_mode_vram_rdata !== 32'h56781234 || sprite_vram_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL scr_rdata: got scr=%h spr=%h, want 56781234/0", screen_mode_vram_rdata, sprite_vram_rdata);
        end
    endtask

    task automatic test_priority();
        screen_mode_vram_address = 17'h00100;
        sprite_vram_address      = 17'h00206;
        screen_mode_vram_valid   = 1'b1;
        sprite_vram_valid        = 1'b1;
        tick();
        screen_mode_vram_valid   = 1'b0;
        sprite_vram_valid        = 1'b0;
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00100) begin
            n_bad++;
            $display("FAIL prio_first: got valid=%b addr=%h, want 1/00100", vram_valid, vram_address);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00204) begin
            n_bad++;
            $display("FAIL prio_second: got valid=%b addr=%h, want 1/00204", vram_valid, vram_address);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_idle: got valid=%b, want 0", vram_valid);
        end
        respond(32'hAAAA0001);
        n_cmp++;
        if (screen_mode_vram_rdata !== 32'hAAAA0001 || sprite_vram_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL prio_rsp1: got scr=%h spr=%h, want AAAA0001/0", screen_mode_vram_rdata, sprite_vram_rdata);
        end
        respond(32'hBBBB0002);
        n_cmp++;
        if (screen_mode_vram_rdata !== 32'hAAAA0001 || sprite_vram_rdata !== 32'hBBBB0002) begin
            n_bad++;
            $display("FAIL prio_rsp2: got scr=%h spr=%h, want AAAA0001/BBBB0002", screen_mode_vram_rdata, sprite_vram_rdata);
        end
    endtask

    task automatic test_rdata8();
        logic [7:0] exp8;
`ifdef VDP_VRAM_SPRITE_RDATA8_EN
        exp8 = 8'h33;
`else
        exp8 = 8'h00;
`endif
        sprite_vram_address = 17'h00102;
        sprite_vram_valid   = 1'b1;
        tick();
        sprite_vram_valid   = 1'b0;
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00100) begin
            n_bad++;
            $display("FAIL r8_issue: got valid=%b addr=%h, want 1/00100", vram_valid, vram_address);
        end
        tick();
        respond(32'h44332211);
        n_cmp++;
        if (sprite_vram_rdata !== 32'h44332211 || sprite_vram_rdata8 !== exp8) begin
            n_bad++;
            $display("FAIL r8_data: got spr=%h spr8=%h, want 44332211/%h", sprite_vram_rdata, sprite_vram_rdata8, exp8);
        end
    endtask

    task automatic test_ready_low();
        vram_ready          = 1'b0;
        sprite_vram_valid   = 1'b1;
        sprite_vram_address = 17'h00010;
        tick();
        sprite_vram_address = 17'h00020;
        tick();
        sprite_vram_valid   = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (vram_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rdy_hold: got valid=%b, want 0", vram_valid);
        end
        vram_ready = 1'b1;
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00020) begin
            n_bad++;
            $display("FAIL rdy_issue: got valid=%b addr=%h, want 1/00020", vram_valid, vram_address);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rdy_dropped: got valid=%b, want 0 (older request must be dropped)", vram_valid);
        end
        respond(32'h0000C0DE);
        n_cmp++;
        if (sprite_vram_rdata !== 32'h0000C0DE) begin
            n_bad++;
            $display("FAIL rdy_rsp: got spr=%h, want 0000C0DE", sprite_vram_rdata);
        end
    endtask

    task automatic test_outstanding_limit();
        screen_mode_vram_address = 17'h00300;
        sprite_vram_address      = 17'h00400;
        screen_mode_vram_valid   = 1'b1;
        sprite_vram_valid        = 1'b1;
        tick();
        // Screen repeats on the issuing edge, so its slot stays set with 00500.
        sprite_vram_valid        = 1'b0;
        screen_mode_vram_address = 17'h00500;
        tick();
        screen_mode_vram_valid   = 1'b0;
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00300) begin
            n_bad++;
            $display("FAIL lim_cmd1: got valid=%b addr=%h, want 1/00300", vram_valid, vram_address);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00500) begin
            n_bad++;
            $display("FAIL lim_cmd2: got valid=%b addr=%h, want 1/00500", vram_valid, vram_address);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (vram_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL lim_block%0d: got valid=%b, want 0", i, vram_valid);
            end
        end
        respond(32'h11111111);
        n_cmp++;
        if (vram_valid !== 1'b0 || screen_mode_vram_rdata !== 32'h11111111) begin
            n_bad++;
            $display("FAIL lim_pop: got valid=%b scr=%h, want 0/11111111", vram_valid, screen_mode_vram_rdata);
        end
        tick();
        n_cmp++;
        if (vram_valid !== 1'b1 || vram_address !== 17'h00400) begin
            n_bad++;
            $display("FAIL lim_cmd3: got valid=%b addr=%h, want 1/00400", vram_valid, vram_address);
        end
        respond(32'h22222222);
        respond(32'h33333333);
        n_cmp++;
        if (screen_mode_vram_rdata !== 32'h22222222 || sprite_vram_rdata !== 32'h33333333) begin
            n_bad++;
            $display("FAIL lim_drain: got scr=%h spr=%h, want 22222222/33333333", screen_mode_vram_rdata, sprite_vram_rdata);
        end
    endtask

    task automatic test_reset_mid();
        screen_mode_vram_address = 17'h00600;
        sprite_vram_address      = 17'h00700;
        screen_mode_vram_valid   = 1'b1;
        sprite_vram_valid        = 1'b1;
        tick();
        screen_mode_vram_valid   = 1'b0;
        sprite_vram_valid        = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (vram_valid !== 1'b0 || screen_mode_vram_rdata !== 32'd0 || sprite_vram_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_async_clear: got valid=%b scr=%h spr=%h, want 0", vram_valid, screen_mode_vram_rdata, sprite_vram_rdata);
        end
        tick();
        reset_n = 1'b1;
        tick();
        respond(32'hFFFFFFFF);
        tick();
        n_cmp++;
        if (vram_valid !== 1'b0 || vram_address !== 17'd0 || screen_mode_vram_rdata !== 32'd0
            || sprite_vram_rdata !== 32'd0 || sprite_vram_rdata8 !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_empty_pop: got valid=%b addr=%h scr=%h spr=%h spr8=%h, want all 0",
                     vram_valid, vram_address, screen_mode_vram_rdata, sprite_vram_rdata, sprite_vram_rdata8);
        end
    endtask

    initial begin
        n_cmp                    = 0;
        n_bad                    = 0;
        reset_n                  = 1'b0;
        screen_mode_vram_address = 17'd0;
        screen_mode_vram_valid   = 1'b0;
        sprite_vram_address      = 17'd0;
        sprite_vram_valid        = 1'b0;
        vram_ready               = 1'b0;
        vram_rdata               = 32'd0;
        vram_rdata_en            = 1'b0;
        tick();
        tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_screen_read();
        test_priority();
        test_rdata8();
        test_ready_low();
        test_outstanding_limit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
